// File: rtl/vga_sync_gen_if.sv
// Pixel coordinate bus shared with the drawer chain.
// The sync generator drives coordinates out and takes the drawers' colour back.
interface vga_sync_gen_if;
    localparam int unsigned COORD_W = 11;

    logic [COORD_W-1:0] pixelX;
    logic [COORD_W-1:0] pixelY;
    logic               startOfFrame;
    logic [7:0]         RGBIn;

    modport master (output pixelX, output pixelY, output startOfFrame, input RGBIn);
    modport slave  (input pixelX, input pixelY, input startOfFrame, output RGBIn);
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: drives pixel coordinates to the drawer chain and
// realigns the returned 8-bit colour with delayed sync/blank for the DAC outputs.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE    = 640,
    parameter int unsigned H_FRONT      = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BACK       = 48,
    parameter int unsigned V_VISIBLE    = 480,
    parameter int unsigned V_FRONT      = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BACK       = 33,
    parameter int unsigned DRAW_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetN,
    vga_sync_gen_if.master    pix,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hSync,
    output logic              vSync,
    output logic              blankN
);
    localparam int unsigned CW       = 11;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned STAGES   = DRAW_LATENCY + 1;

    logic [CW-1:0]     r_h_cnt;
    logic [CW-1:0]     r_v_cnt;
    logic              r_sof;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_active;
    logic              w_hs;
    logic              w_vs;
    logic [STAGES-1:0] r_act_d;
    logic [STAGES-1:0] r_hs_d;
    logic [STAGES-1:0] r_vs_d;
    logic [STAGES-1:0] w_act_nxt;
    logic [STAGES-1:0] w_hs_nxt;
    logic [STAGES-1:0] w_vs_nxt;
    logic              w_act_pre;
    logic [7:0]        r_red;
    logic [7:0]        r_green;
    logic [7:0]        r_blue;

    assign w_h_last = (r_h_cnt == CW'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == CW'(V_TOTAL - 1));

    // Raster counters; startOfFrame is registered so it lines up with the (0,0) count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_sof   <= 1'b0;
        end else begin
            r_sof <= w_h_last && w_v_last;
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + CW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + CW'(1);
            end
        end
    end

    assign w_active = (r_h_cnt < CW'(H_VISIBLE)) && (r_v_cnt < CW'(V_VISIBLE));
    assign w_hs     = !((r_h_cnt >= CW'(HS_START)) && (r_h_cnt < CW'(HS_END)));
    assign w_vs     = !((r_v_cnt >= CW'(VS_START)) && (r_v_cnt < CW'(VS_END)));

    // Next contents of each delay line; the top bit is what the final stage loads next.
    assign w_act_nxt = STAGES'({r_act_d, w_active});
    assign w_hs_nxt  = STAGES'({r_hs_d, w_hs});
    assign w_vs_nxt  = STAGES'({r_vs_d, w_vs});
    assign w_act_pre = w_act_nxt[STAGES-1];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_act_d <= '0;
            r_hs_d  <= '1;
            r_vs_d  <= '1;
        end else begin
            r_act_d <= w_act_nxt;
            r_hs_d  <= w_hs_nxt;
            r_vs_d  <= w_vs_nxt;
        end
    end

    // Colour register loads with the final delay stage; blanking gates RGBIn out entirely.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (w_act_pre) begin
            r_red   <= {pix.RGBIn[5:3], pix.RGBIn[5:3], pix.RGBIn[5:4]};
            r_green <= {pix.RGBIn[2:0], pix.RGBIn[2:0], pix.RGBIn[2:1]};
            r_blue  <= {pix.RGBIn[7:6], pix.RGBIn[7:6], pix.RGBIn[7:6], pix.RGBIn[7:6]};
        end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end
    end

    assign pix.pixelX       = r_h_cnt;
    assign pix.pixelY       = r_v_cnt;
    assign pix.startOfFrame = r_sof;
    assign red              = r_red;
    assign green            = r_green;
    assign blue             = r_blue;
    assign hSync            = r_hs_d[STAGES-1];
    assign vSync            = r_vs_d[STAGES-1];
    assign blankN           = r_act_d[STAGES-1];
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a full-size 640x480 instance (drawer latency 1) and a small-raster
// instance (drawer latency 3) so whole-frame behaviour fits in a short run.
module tb_vga_sync_gen;
    localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33, A_LAT = 1;
    localparam int A_HT = 800, A_VT = 525;
    localparam int B_HV = 20,  B_HF = 4,  B_HS = 6,  B_HB = 5;
    localparam int B_VV = 10,  B_VF = 2,  B_VS = 2,  B_VB = 5,  B_LAT = 3;
    localparam int B_HT = 35,  B_VT = 19;

    logic clk = 1'b0;
    logic resetN;
    logic ramp_mode;
    logic [7:0] rgb_const;
    int n_checks = 0;
    int n_errors = 0;

    always #20 clk = ~clk;

    vga_sync_gen_if pix_a ();
    vga_sync_gen_if pix_b ();

    logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic hSync_a, vSync_a, blankN_a, hSync_b, vSync_b, blankN_b;
    logic [26:0] obs_a, obs_b;
    logic [22:0] pobs_a, pobs_b;

    assign obs_a  = {hSync_a, vSync_a, blankN_a, red_a, green_a, blue_a};
    assign obs_b  = {hSync_b, vSync_b, blankN_b, red_b, green_b, blue_b};
    assign pobs_a = {pix_a.startOfFrame, pix_a.pixelY, pix_a.pixelX};
    assign pobs_b = {pix_b.startOfFrame, pix_b.pixelY, pix_b.pixelX};

    vga_sync_gen #(
        .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .DRAW_LATENCY(A_LAT)
    ) u_a (
        .clk(clk), .resetN(resetN), .pix(pix_a),
        .red(red_a), .green(green_a), .blue(blue_a),
        .hSync(hSync_a), .vSync(vSync_a), .blankN(blankN_a)
    );

    vga_sync_gen #(
        .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .DRAW_LATENCY(B_LAT)
    ) u_b (
        .clk(clk), .resetN(resetN), .pix(pix_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .hSync(hSync_b), .vSync(vSync_b), .blankN(blankN_b)
    );

    // Drawer models: colour = pixelX[7:0] after N registers, X while that pixel is blanked.
    logic [10:0] a_x1, a_y1;
    logic [10:0] b_x0, b_y0, b_x1, b_y1, b_x2, b_y2;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            a_x1 <= '0; a_y1 <= '0;
            b_x0 <= '0; b_y0 <= '0; b_x1 <= '0; b_y1 <= '0; b_x2 <= '0; b_y2 <= '0;
        end else begin
            a_x1 <= pix_a.pixelX; a_y1 <= pix_a.pixelY;
            b_x0 <= pix_b.pixelX; b_y0 <= pix_b.pixelY;
            b_x1 <= b_x0;         b_y1 <= b_y0;
            b_x2 <= b_x1;         b_y2 <= b_y1;
        end
    end

    assign pix_a.RGBIn = !ramp_mode ? rgb_const :
                         ((a_x1 < 11'(A_HV)) && (a_y1 < 11'(A_VV))) ? a_x1[7:0] : 8'hxx;
    assign pix_b.RGBIn = !ramp_mode ? rgb_const :
                         ((b_x2 < 11'(B_HV)) && (b_y2 < 11'(B_VV))) ? b_x2[7:0] : 8'hxx;

    function automatic logic [23:0] expand(input logic [7:0] v);
        logic [2:0] r, g;
        logic [1:0] b;
        r = v[5:3];
        g = v[2:0];
        b = v[7:6];
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

    // Expected {hSync, vSync, blankN, red, green, blue} t edges after reset release.
    function automatic logic [26:0] exp_out(input int t, input int lat,
                                            input int hv, input int hf, input int hsw, input int hb,
                                            input int vv, input int vf, input int vsw, input int vb,
                                            input logic ramp, input logic [7:0] cval);
        int ht, vt, c, x, y;
        logic act, hs, vs;
        logic [7:0] src;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (t < lat + 1) return {3'b110, 24'h000000};
        c   = t - lat - 1;
        x   = c % ht;
        y   = (c / ht) % vt;
        act = (x < hv) && (y < vv);
        hs  = !((x >= hv + hf) && (x < hv + hf + hsw));
        vs  = !((y >= vv + vf) && (y < vv + vf + vsw));
        src = ramp ? 8'(x) : cval;
        return {hs, vs, act, act ? expand(src) : 24'h000000};
    endfunction

    function automatic logic [22:0] exp_pix(input int t, input int ht, input int vt);
        logic sof;
        sof = (t > 0) && ((t % (ht * vt)) == 0);
        return {sof, 11'((t / ht) % vt), 11'(t % ht)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    int mm_a, mm_b, mp_a, mp_b;

    task automatic cycle_check(input int t);
        if (obs_a !== exp_out(t, A_LAT, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, 1'b1, 8'h00)) mm_a++;
        if (obs_b !== exp_out(t, B_LAT, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, 1'b1, 8'h00)) mm_b++;
        if (pobs_a !== exp_pix(t, A_HT, A_VT)) mp_a++;
        if (pobs_b !== exp_pix(t, B_HT, B_VT)) mp_b++;
    endtask

    int tc;
    int hs_low_a, blank_hi_a, fall1_a, fall2_a, width_a, hs_run;
    int vs_low_b, blank_hi_b, blank_rise_b, vs_fall_b;
    logic prev_hs_a, prev_vs_b, prev_bl_b;

    initial begin
        resetN = 1'b0; ramp_mode = 1'b1; rgb_const = 8'h00;
        mm_a = 0; mm_b = 0; mp_a = 0; mp_b = 0;
        hs_low_a = 0; blank_hi_a = 0; fall1_a = -1; fall2_a = -1; width_a = -1; hs_run = 0;
        vs_low_b = 0; blank_hi_b = 0; blank_rise_b = 0; vs_fall_b = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("a_in_reset_out", 32'(obs_a), 32'({3'b110, 24'h000000}));
        chk("a_in_reset_pix", 32'(pobs_a), 32'h0);
        chk("b_in_reset_out", 32'(obs_b), 32'({3'b110, 24'h000000}));
        chk("b_in_reset_pix", 32'(pobs_b), 32'h0);

        resetN = 1'b1;
        prev_hs_a = 1'b1; prev_vs_b = 1'b1; prev_bl_b = 1'b0;
        for (int t = 0; t < 2402; t++) begin
            cycle_check(t);
            if (t == 1)   chk("a_pre_first_blank", 32'(obs_a), 32'({3'b110, 24'h000000}));
            if (t == 2)   chk("a_first_blank_rgb", 32'(obs_a), 32'({3'b111, 24'h000000}));
            if (t == 6)   chk("a_fifth_pixel_rgb", 32'(obs_a), 32'({3'b111, 24'h009200}));
            if (t == 664) chk("b_pre_sof", 32'(pobs_b), 32'({1'b0, 11'd18, 11'd34}));
            if (t == 665) chk("b_first_sof", 32'(pobs_b), 32'({1'b1, 22'h0}));
            if (t >= 802 && t < 2402) begin
                if (!hSync_a) begin hs_low_a++; hs_run++; end
                if (blankN_a) blank_hi_a++;
                if (prev_hs_a && !hSync_a) begin
                    if (fall1_a < 0) fall1_a = t;
                    else if (fall2_a < 0) fall2_a = t;
                end
                if (!prev_hs_a && hSync_a) begin
                    if (width_a < 0) width_a = hs_run;
                    hs_run = 0;
                end
            end
            if (t >= 669 && t < 1334) begin
                if (!vSync_b) vs_low_b++;
                if (blankN_b) blank_hi_b++;
                if (!prev_bl_b && blankN_b) blank_rise_b++;
                if (prev_vs_b && !vSync_b && vs_fall_b < 0) vs_fall_b = t;
            end
            prev_hs_a = hSync_a; prev_vs_b = vSync_b; prev_bl_b = blankN_b;
            @(negedge clk);
        end
        tc = 2402;
        chk("a_cycle_outputs", 32'(mm_a), 32'h0);
        chk("b_cycle_outputs", 32'(mm_b), 32'h0);
        chk("a_cycle_counters", 32'(mp_a), 32'h0);
        chk("b_cycle_counters", 32'(mp_b), 32'h0);
        chk("a_hs_fall_hcnt", 32'((fall1_a - A_LAT - 1) % A_HT), 32'd656);
        chk("a_line_period", 32'(fall2_a - fall1_a), 32'd800);
        chk("a_hs_width", 32'(width_a), 32'd96);
        chk("a_hs_low_2lines", 32'(hs_low_a), 32'd192);
        chk("a_blank_hi_2lines", 32'(blank_hi_a), 32'd1280);
        chk("b_vs_fall_count", 32'((vs_fall_b - B_LAT - 1) % (B_HT * B_VT)), 32'd420);
        chk("b_vs_low_frame", 32'(vs_low_b), 32'd70);
        chk("b_blank_hi_frame", 32'(blank_hi_b), 32'd200);
        chk("b_blank_lines", 32'(blank_rise_b), 32'd10);

        // Constant colour: full white, then 01_100_011.
        ramp_mode = 1'b0; rgb_const = 8'hFF;
        repeat (100) @(negedge clk); tc += 100;
        chk("a_const_ff_active", 32'(obs_a), 32'({3'b111, 24'hFFFFFF}));
        repeat (600) @(negedge clk); tc += 600;
        chk("a_const_ff_blank", 32'(obs_a), 32'({3'b010, 24'h000000}));
        rgb_const = 8'b01_100_011;
        repeat (200) @(negedge clk); tc += 200;
        chk("a_const_63_active", 32'(obs_a), 32'({3'b111, 24'h926D55}));
        chk("b_const_63_blank", 32'(obs_b),
            32'(exp_out(tc, B_LAT, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, 1'b0, 8'h63)));

        // Mid-line asynchronous reset.
        ramp_mode = 1'b1;
        repeat (210) @(negedge clk); tc += 210;
        chk("a_pre_reset_pix", 32'(pobs_a), 32'({1'b0, 11'd4, 11'd312}));
        chk("b_pre_reset_pix", 32'(pobs_b), 32'({1'b0, 11'd5, 11'd12}));
        resetN = 1'b0;
        #1;
        chk("a_async_reset_out", 32'(obs_a), 32'({3'b110, 24'h000000}));
        chk("b_async_reset_out", 32'(obs_b), 32'({3'b110, 24'h000000}));
        chk("a_async_reset_pix", 32'(pobs_a), 32'h0);
        chk("b_async_reset_pix", 32'(pobs_b), 32'h0);
        repeat (3) @(negedge clk);

        resetN = 1'b1;
        mm_a = 0; mm_b = 0; mp_a = 0; mp_b = 0;
        for (int t = 0; t < 120; t++) begin
            cycle_check(t);
            if (t == 3) chk("b_lat3_pre_blank", 32'(obs_b), 32'({3'b110, 24'h000000}));
            if (t == 4) chk("b_lat3_first_blank", 32'(obs_b), 32'({3'b111, 24'h000000}));
            if (t == 9) chk("b_lat3_pixel5", 32'(obs_b), 32'({3'b111, 24'h00B600}));
            @(negedge clk);
        end
        chk("a_restart_outputs", 32'(mm_a), 32'h0);
        chk("b_restart_outputs", 32'(mm_b), 32'h0);
        chk("a_restart_counters", 32'(mp_a), 32'h0);
        chk("b_restart_counters", 32'(mp_b), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
